// File: rtl/echo_pkg.sv
// Shared types and constants for the echo_medidor ultrasonic ranging front end.
package echo_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    HOLD
  } state_e;

  // Bin count saturates here; any width at or past this bin is out of range.
  localparam int unsigned BIN_SAT  = 16;
  // Code shown on A..D for errors and out-of-range results.
  localparam logic [3:0]  ERR_CODE = 4'hF;

  // Shared by the state-time counter and the period counter; fits 3_000_000.
  localparam int unsigned CNT_W = 22;
  // Sub-counter within one distance bin; fits 2900.
  localparam int unsigned SUB_W = 12;
  // Bin counter, 0..16.
  localparam int unsigned BIN_W = 5;

endpackage

// File: rtl/echo_sync.sv
// Two-flop synchroniser for the asynchronous sensor echo, plus single-cycle
// rise/fall pulses derived from the synchronised level.
module echo_sync (
  input  logic clk,
  input  logic rst,
  input  logic echo,
  output logic echo_s,
  output logic rise,
  output logic fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  // Shift chain: metastability flop, synchronised level, previous level.
  always_comb begin
    meta_d = echo;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // Register the chain; reset clears so no spurious edge follows reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign echo_s = sync_q;
  assign rise   = sync_q & ~prev_q;
  assign fall   = ~sync_q & prev_q;

endmodule

// File: rtl/echo_medidor.sv
// Ultrasonic ranging front end: periodic trigger, echo width timing, and
// quantisation into 4-bit distance bins on A..D with RE/RS status.
// Optional macro ECHO_FILTER_EN: a valid result is only presented after two
// consecutive commits give the same bin.
module echo_medidor #(
  parameter int unsigned TRIG_CYCLES    = 500,
  parameter int unsigned BIN_CYCLES     = 2900,
  parameter int unsigned TIMEOUT_CYCLES = 1_250_000,
  parameter int unsigned PERIOD_CYCLES  = 3_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic echo,
  output logic trig,
  output logic A,
  output logic B,
  output logic C,
  output logic D,
  output logic RE,
  output logic RS
);

  import echo_pkg::*;

  localparam logic [CNT_W-1:0] TRIG_LAST    = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST  = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [SUB_W-1:0] SUB_LAST     = SUB_W'(BIN_CYCLES - 1);
  localparam logic [BIN_W-1:0] BIN_MAX      = BIN_W'(BIN_SAT);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic [SUB_W-1:0]   sub_q, sub_d;
  logic [BIN_W-1:0]   bins_q, bins_d;
  logic               trig_q, trig_d;
  logic [3:0]         abcd_q, abcd_d;
  logic               rs_q, rs_d;
  logic               re_q, re_d;
`ifdef ECHO_FILTER_EN
  logic [3:0]         cand_q, cand_d;
  logic               cand_vld_q, cand_vld_d;
`endif

  logic echo_s;
  logic echo_rise;
  logic echo_fall;
  logic commit;
  logic timeout_err;

  echo_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .echo   (echo),
    .echo_s (echo_s),
    .rise   (echo_rise),
    .fall   (echo_fall)
  );

  // Sequencing FSM: trigger, wait for echo, time it, then hold out the period.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    period_d    = (state_q == IDLE) ? '0 : period_q + CNT_W'(1);
    sub_d       = sub_q;
    bins_d      = bins_q;
    commit      = 1'b0;
    timeout_err = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d  = TRIG;
          cnt_d    = '0;
          period_d = '0;
        end
      end
      TRIG: begin
        if (cnt_q == TRIG_LAST) begin
          state_d = WAIT_RISE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_RISE: begin
        if (echo_rise) begin
          // The rise cycle is itself the first high cycle, so counting starts at 1.
          state_d = MEASURE;
          cnt_d   = '0;
          sub_d   = SUB_W'(1);
          bins_d  = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          timeout_err = 1'b1;
          state_d     = HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      MEASURE: begin
        if (echo_fall) begin
          commit  = 1'b1;
          state_d = HOLD;
        end else if (cnt_q == TIMEOUT_LAST) begin
          timeout_err = 1'b1;
          state_d     = HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (echo_s) begin
            if (sub_q == SUB_LAST) begin
              sub_d = '0;
              if (bins_q != BIN_MAX) begin
                bins_d = bins_q + BIN_W'(1);
              end
            end else begin
              sub_d = sub_q + SUB_W'(1);
            end
          end
        end
      end
      HOLD: begin
        if (period_q == PERIOD_LAST) begin
          if (en) begin
            state_d  = TRIG;
            cnt_d    = '0;
            period_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Result update on commit or timeout; trig is registered from the next state.
  always_comb begin
    trig_d = (state_d == TRIG);
    abcd_d = abcd_q;
    rs_d   = rs_q;
    re_d   = re_q;
`ifdef ECHO_FILTER_EN
    cand_d     = cand_q;
    cand_vld_d = cand_vld_q;
`endif
    if (timeout_err || (commit && (bins_q >= BIN_MAX))) begin
      // Out-of-range widths behave like errors: shown at once, candidate dropped.
      abcd_d = ERR_CODE;
      rs_d   = 1'b1;
      re_d   = 1'b1;
`ifdef ECHO_FILTER_EN
      cand_vld_d = 1'b0;
`endif
    end else if (commit) begin
`ifdef ECHO_FILTER_EN
      if (cand_vld_q && (cand_q == bins_q[3:0])) begin
        abcd_d = bins_q[3:0];
        rs_d   = 1'b0;
        re_d   = 1'b1;
      end else begin
        cand_d     = bins_q[3:0];
        cand_vld_d = 1'b1;
      end
`else
      abcd_d = bins_q[3:0];
      rs_d   = 1'b0;
      re_d   = 1'b1;
`endif
    end
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      sub_q    <= '0;
      bins_q   <= '0;
      trig_q   <= 1'b0;
      abcd_q   <= '0;
      rs_q     <= 1'b0;
      re_q     <= 1'b0;
`ifdef ECHO_FILTER_EN
      cand_q     <= '0;
      cand_vld_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      sub_q    <= sub_d;
      bins_q   <= bins_d;
      trig_q   <= trig_d;
      abcd_q   <= abcd_d;
      rs_q     <= rs_d;
      re_q     <= re_d;
`ifdef ECHO_FILTER_EN
      cand_q     <= cand_d;
      cand_vld_q <= cand_vld_d;
`endif
    end
  end

  assign trig         = trig_q;
  assign {A, B, C, D} = abcd_q;
  assign RS           = rs_q;
  assign RE           = re_q;

endmodule
